// File: rtl/load_buffer_pkg.sv
// Shared types for the load buffer: input/writeback payloads, entry state and
// the byte merge / extension helper.
package load_buffer_pkg;

  localparam int unsigned LB_SZ    = 4;
  localparam int unsigned LB_IDX_W = $clog2(LB_SZ);
  localparam int unsigned B_MASK_W = 4;
  localparam int unsigned PREG_W   = 6;

  typedef enum logic [2:0] {
    LF_LB  = 3'd0,
    LF_LH  = 3'd1,
    LF_LW  = 3'd2,
    LF_LBU = 3'd3,
    LF_LHU = 3'd4
  } load_func_t;

  typedef enum logic [2:0] {
    LB_EMPTY  = 3'd0,
    LB_ISSUE  = 3'd1,
    LB_WAIT   = 3'd2,
    LB_READY  = 3'd3,
    LB_ORPHAN = 3'd4
  } lb_state_t;

  typedef struct packed {
    logic                valid;
    logic [PREG_W-1:0]   dest_reg_idx;
    logic [31:0]         load_addr;
    load_func_t          load_func;
    logic [3:0]          byte_mask;
    logic [B_MASK_W-1:0] bm;
    logic [31:0]         fwd_data;
    logic [3:0]          fwd_mask;
  } load_buffer_packet_t;

  typedef struct packed {
    logic [PREG_W-1:0] dest_reg_idx;
    logic [31:0]       data;
  } lb_wb_packet_t;

  typedef struct packed {
    lb_state_t           state;
    logic [PREG_W-1:0]   dest;
    logic [31:0]         addr;
    load_func_t          func;
    logic [B_MASK_W-1:0] bm;
    logic [31:0]         fwd_data;
    logic [3:0]          fwd_mask;
    logic [31:0]         data;
  } lb_entry_t;

  localparam load_buffer_packet_t NOP_LOAD_BUFFER_PACKET = '0;
  localparam lb_wb_packet_t       NOP_LB_WB_PACKET       = '0;

  // Forwarded bytes override cache bytes, then align to the load offset and extend.
  function automatic logic [31:0] lb_merge(input logic [31:0] cache, input logic [31:0] fwd,
                                           input logic [3:0] fmask, input logic [1:0] off,
                                           input load_func_t func);
    logic [31:0] w;
    logic [31:0] s;
    for (int b = 0; b < 4; b++) begin
      w[8*b +: 8] = fmask[b] ? fwd[8*b +: 8] : cache[8*b +: 8];
    end
    s = w >> {off, 3'b000};
    case (func)
      LF_LB:   lb_merge = {{24{s[7]}}, s[7:0]};
      LF_LH:   lb_merge = {{16{s[15]}}, s[15:0]};
      LF_LBU:  lb_merge = {24'd0, s[7:0]};
      LF_LHU:  lb_merge = {16'd0, s[15:0]};
      default: lb_merge = s;
    endcase
  endfunction

endpackage

// File: rtl/load_buffer_lb_psel.sv
// Lowest-index one-hot selector.
module lb_psel #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_c
);

  assign gnt_c = req & (~req + N'(1));

endmodule

// File: rtl/load_buffer.sv
// Load buffer: parks loads awaiting D-cache data or writeback, issues one cache read
// per cycle, merges forwarded bytes, and arbitrates for the CDB.
module load_buffer
  import load_buffer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  load_buffer_packet_t lb_packet_in,
  output logic                load_buffer_free,
  output logic                dc_req_valid,
  output logic [31:0]         dc_req_addr,
  output logic [LB_IDX_W-1:0] dc_req_tag,
  input  logic                dc_req_accept,
  input  logic                dc_resp_valid,
  input  logic [LB_IDX_W-1:0] dc_resp_tag,
  input  logic [31:0]         dc_resp_data,
  output logic                lb_wb_valid,
  output lb_wb_packet_t       lb_wb_packet,
  input  logic                lb_wb_grant,
  input  logic [B_MASK_W-1:0] b_mm_resolve,
  input  logic                b_mm_mispred
);

  lb_entry_t entries   [LB_SZ];
  lb_entry_t entries_n [LB_SZ];

  logic [LB_SZ-1:0] empty_vec, issue_vec, ready_vec, kill_vec;
  logic [LB_SZ-1:0] alloc_gnt, issue_gnt, wb_gnt;
  logic             in_kill, alloc_en;

  // Squashed entries drop out of issue/writeback arbitration in the resolve cycle.
  always_comb begin
    empty_vec = '0;
    issue_vec = '0;
    ready_vec = '0;
    kill_vec  = '0;
    for (int i = 0; i < LB_SZ; i++) begin
      empty_vec[i] = (entries[i].state == LB_EMPTY);
      kill_vec[i]  = b_mm_mispred && (|(entries[i].bm & b_mm_resolve)) &&
                     (entries[i].state inside {LB_ISSUE, LB_WAIT, LB_READY});
      issue_vec[i] = (entries[i].state == LB_ISSUE) && !kill_vec[i];
      ready_vec[i] = (entries[i].state == LB_READY) && !kill_vec[i];
    end
    in_kill          = b_mm_mispred && (|(lb_packet_in.bm & b_mm_resolve));
    load_buffer_free = |empty_vec;
    alloc_en         = lb_packet_in.valid && load_buffer_free && !in_kill;
  end

  lb_psel #(.N(LB_SZ)) u_alloc_sel (.req(empty_vec), .gnt_c(alloc_gnt));
  lb_psel #(.N(LB_SZ)) u_issue_sel (.req(issue_vec), .gnt_c(issue_gnt));
  lb_psel #(.N(LB_SZ)) u_wb_sel    (.req(ready_vec), .gnt_c(wb_gnt));

  always_comb begin
    dc_req_valid = |issue_gnt;
    dc_req_addr  = '0;
    dc_req_tag   = '0;
    lb_wb_valid  = |wb_gnt;
    lb_wb_packet = NOP_LB_WB_PACKET;
    for (int i = 0; i < LB_SZ; i++) begin
      if (issue_gnt[i]) begin
        dc_req_addr = {entries[i].addr[31:2], 2'b00};
        dc_req_tag  = LB_IDX_W'(i);
      end
      if (wb_gnt[i]) begin
        lb_wb_packet.dest_reg_idx = entries[i].dest;
        lb_wb_packet.data         = entries[i].data;
      end
    end
  end

  // Per-entry next state; a squash overrides the normal transition.
  always_comb begin
    for (int i = 0; i < LB_SZ; i++) begin
      logic resp_hit;
      entries_n[i] = entries[i];
      resp_hit     = dc_resp_valid && (dc_resp_tag == LB_IDX_W'(i));
      case (entries[i].state)
        LB_EMPTY: begin
          if (alloc_en && alloc_gnt[i]) begin
            entries_n[i].dest     = lb_packet_in.dest_reg_idx;
            entries_n[i].addr     = lb_packet_in.load_addr;
            entries_n[i].func     = lb_packet_in.load_func;
            entries_n[i].bm       = lb_packet_in.bm;
            entries_n[i].fwd_data = lb_packet_in.fwd_data;
            entries_n[i].fwd_mask = lb_packet_in.fwd_mask;
            if ((lb_packet_in.byte_mask & ~lb_packet_in.fwd_mask) == 4'd0) begin
              entries_n[i].state = LB_READY;
              entries_n[i].data  = lb_merge(32'd0, lb_packet_in.fwd_data, 4'hF,
                                            lb_packet_in.load_addr[1:0], lb_packet_in.load_func);
            end else begin
              entries_n[i].state = LB_ISSUE;
              entries_n[i].data  = '0;
            end
          end
        end
        LB_ISSUE:  if (issue_gnt[i] && dc_req_accept) entries_n[i].state = LB_WAIT;
        LB_WAIT: begin
          if (resp_hit) begin
            entries_n[i].state = LB_READY;
            entries_n[i].data  = lb_merge(dc_resp_data, entries[i].fwd_data, entries[i].fwd_mask,
                                          entries[i].addr[1:0], entries[i].func);
          end
        end
        LB_READY:  if (wb_gnt[i] && lb_wb_grant) entries_n[i].state = LB_EMPTY;
        LB_ORPHAN: if (resp_hit) entries_n[i].state = LB_EMPTY;
        default:   entries_n[i].state = LB_EMPTY;
      endcase
      if (kill_vec[i]) begin
        entries_n[i].state = ((entries[i].state == LB_WAIT) && !resp_hit) ? LB_ORPHAN : LB_EMPTY;
      end else if (!b_mm_mispred) begin
        entries_n[i].bm = entries_n[i].bm & ~b_mm_resolve;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LB_SZ; i++) begin
      if (reset) entries[i] <= '0;
      else       entries[i] <= entries_n[i];
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// Self-checking bench for load_buffer: a vector table of single loads plus
// hand-written sequences for fill, branch squash and reset.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  load_buffer_packet_t lb_packet_in;
  logic                load_buffer_free;
  logic                dc_req_valid;
  logic [31:0]         dc_req_addr;
  logic [LB_IDX_W-1:0] dc_req_tag;
  logic                dc_req_accept;
  logic                dc_resp_valid;
  logic [LB_IDX_W-1:0] dc_resp_tag;
  logic [31:0]         dc_resp_data;
  logic                lb_wb_valid;
  lb_wb_packet_t       lb_wb_packet;
  logic                lb_wb_grant;
  logic [B_MASK_W-1:0] b_mm_resolve;
  logic                b_mm_mispred;

  int checks = 0;
  int errors = 0;
  lb_wb_packet_t exp_q[$];

  load_buffer dut (
    .clock(clock), .reset(reset), .lb_packet_in(lb_packet_in),
    .load_buffer_free(load_buffer_free), .dc_req_valid(dc_req_valid),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag), .dc_req_accept(dc_req_accept),
    .dc_resp_valid(dc_resp_valid), .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .lb_wb_valid(lb_wb_valid), .lb_wb_packet(lb_wb_packet), .lb_wb_grant(lb_wb_grant),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred)
  );

  always #5 clock = ~clock;

  typedef struct {
    load_func_t  func;
    logic [31:0] addr;
    logic [3:0]  bmask;
    logic [3:0]  fmask;
    logic [31:0] fdata;
    logic [31:0] cache;
    logic [31:0] exp;
    logic        need_req;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_load(input logic [PREG_W-1:0] dest, input logic [31:0] addr,
                            input load_func_t func, input logic [3:0] bmask,
                            input logic [B_MASK_W-1:0] bm, input logic [31:0] fdata,
                            input logic [3:0] fmask);
    lb_packet_in.valid        = 1'b1;
    lb_packet_in.dest_reg_idx = dest;
    lb_packet_in.load_addr    = addr;
    lb_packet_in.load_func    = func;
    lb_packet_in.byte_mask    = bmask;
    lb_packet_in.bm           = bm;
    lb_packet_in.fwd_data     = fdata;
    lb_packet_in.fwd_mask     = fmask;
    tick();
    lb_packet_in = NOP_LOAD_BUFFER_PACKET;
  endtask

  task automatic push_exp(input logic [PREG_W-1:0] dest, input logic [31:0] data);
    lb_wb_packet_t p;
    p.dest_reg_idx = dest;
    p.data         = data;
    exp_q.push_back(p);
  endtask

  // Wait (bounded) for a writeback, compare against the scoreboard head, then grant it.
  task automatic collect_wb(input string name);
    int n = 0;
    lb_wb_packet_t e;
    while (!lb_wb_valid && n < 20) begin
      tick();
      n++;
    end
    if (!lb_wb_valid) begin
      check({name, "_wb_timeout"}, 32'(lb_wb_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check({name, "_wb_unexpected"}, 32'(lb_wb_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({name, "_wb_data"}, lb_wb_packet.data, e.data);
      check({name, "_wb_dest"}, 32'(lb_wb_packet.dest_reg_idx), 32'(e.dest_reg_idx));
      lb_wb_grant = 1'b1;
      tick();
      lb_wb_grant = 1'b0;
    end
  endtask

  // Expect a request from 'tag', accept it, respond two cycles later, collect the result.
  task automatic serve(input string name, input logic [LB_IDX_W-1:0] tag, input logic [31:0] data);
    check({name, "_req_valid"}, 32'(dc_req_valid), 32'd1);
    check({name, "_req_tag"}, 32'(dc_req_tag), 32'(tag));
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    repeat (2) tick();
    check({name, "_no_early_wb"}, 32'(lb_wb_valid), 32'd0);
    dc_resp_valid = 1'b1;
    dc_resp_tag   = tag;
    dc_resp_data  = data;
    tick();
    dc_resp_valid = 1'b0;
    collect_wb(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{LF_LW,  32'h100, 4'b1111, 4'b0000, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{LF_LB,  32'h103, 4'b1000, 4'b0000, 32'h0,        32'h80FFFFFF, 32'hFFFFFF80, 1'b1};
    vecs[2] = '{LF_LBU, 32'h103, 4'b1000, 4'b0000, 32'h0,        32'h80FFFFFF, 32'h00000080, 1'b1};
    vecs[3] = '{LF_LH,  32'h102, 4'b1100, 4'b1100, 32'h12340000, 32'h0,        32'h00001234, 1'b0};
    vecs[4] = '{LF_LHU, 32'h100, 4'b0011, 4'b0001, 32'h000000AA, 32'h123480FF, 32'h000080AA, 1'b1};
    vecs[5] = '{LF_LH,  32'h100, 4'b0011, 4'b0001, 32'h000000AA, 32'h123480FF, 32'hFFFF80AA, 1'b1};
    vecs[6] = '{LF_LB,  32'h101, 4'b0010, 4'b0000, 32'h0,        32'h00007F00, 32'h0000007F, 1'b1};
    vecs[7] = '{LF_LW,  32'h204, 4'b1111, 4'b1010, 32'h11002200, 32'hAABBCCDD, 32'h11BB22DD, 1'b1};
    vecs[8] = '{LF_LBU, 32'h202, 4'b0100, 4'b0100, 32'h00550000, 32'h0,        32'h00000055, 1'b0};

    reset = 1'b1;
    lb_packet_in = NOP_LOAD_BUFFER_PACKET;
    dc_req_accept = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_tag = '0;
    dc_resp_data = '0;
    lb_wb_grant = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_free", 32'(load_buffer_free), 32'd1);
    check("rst_req_valid", 32'(dc_req_valid), 32'd0);
    check("rst_wb_valid", 32'(lb_wb_valid), 32'd0);

    // Single loads through an empty buffer
    for (int v = 0; v < 9; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      drive_load(PREG_W'(10 + v), vecs[v].addr, vecs[v].func, vecs[v].bmask, '0,
                 vecs[v].fdata, vecs[v].fmask);
      push_exp(PREG_W'(10 + v), vecs[v].exp);
      check({nm, "_req_next_cycle"}, 32'(dc_req_valid), 32'(vecs[v].need_req));
      if (vecs[v].need_req) begin
        check({nm, "_req_addr"}, dc_req_addr, vecs[v].addr & ~32'd3);
        serve(nm, '0, vecs[v].cache);
      end else begin
        check({nm, "_fwd_ready"}, 32'(lb_wb_valid), 32'd1);
        collect_wb(nm);
      end
      check({nm, "_free_after"}, 32'(load_buffer_free), 32'd1);
    end

    // Fill all entries with requests held off
    for (int k = 0; k < 4; k++) begin
      drive_load(PREG_W'(40 + k), 32'h500 + 32'(4 * k), LF_LW, 4'hF, '0, '0, '0);
      push_exp(PREG_W'(40 + k), 32'hC0DE0000 + 32'(k));
    end
    check("full_free", 32'(load_buffer_free), 32'd0);
    drive_load(6'd63, 32'h600, LF_LW, 4'hF, '0, '0, '0);
    check("full_drop_free", 32'(load_buffer_free), 32'd0);
    check("full_req_tag", 32'(dc_req_tag), 32'd0);
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_tag = 2'd0;
    dc_resp_data = 32'hC0DE0000;
    tick();
    dc_resp_valid = 1'b0;
    check("full_ready_still_full", 32'(load_buffer_free), 32'd0);
    collect_wb("full0");
    check("full_free_after_grant", 32'(load_buffer_free), 32'd1);
    for (int k = 1; k < 4; k++) serve($sformatf("full%0d", k), LB_IDX_W'(k), 32'hC0DE0000 + 32'(k));

    // Mispredict while WAIT -> orphan keeps its slot until the late response
    drive_load(6'd20, 32'h300, LF_LW, 4'hF, 4'b0010, '0, '0);
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    tick();
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    check("orphan_no_req", 32'(dc_req_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive_load(PREG_W'(21 + k), 32'h310 + 32'(4 * k), LF_LW, 4'hF, '0, '0, '0);
      push_exp(PREG_W'(21 + k), 32'h000000A0 + 32'(k));
    end
    check("orphan_holds_slot", 32'(load_buffer_free), 32'd0);
    dc_resp_valid = 1'b1;
    dc_resp_tag = 2'd0;
    dc_resp_data = 32'hBAD0BAD0;
    tick();
    dc_resp_valid = 1'b0;
    check("orphan_freed", 32'(load_buffer_free), 32'd1);
    check("orphan_no_wb", 32'(lb_wb_valid), 32'd0);
    for (int k = 1; k < 4; k++)
      serve($sformatf("orph%0d", k), LB_IDX_W'(k), 32'h000000A0 + 32'(k - 1));

    // Correct prediction clears the mask bit so a later mispredict leaves it alone
    drive_load(6'd30, 32'h400, LF_LW, 4'hF, 4'b0010, '0, '0);
    push_exp(6'd30, 32'h5555AAAA);
    dc_req_accept = 1'b1;
    tick();
    dc_req_accept = 1'b0;
    b_mm_resolve = 4'b0010;
    tick();
    b_mm_resolve = '0;
    dc_resp_valid = 1'b1;
    dc_resp_tag = 2'd0;
    dc_resp_data = 32'h5555AAAA;
    tick();
    dc_resp_valid = 1'b0;
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    #1;
    check("cleared_bm_survives", 32'(lb_wb_valid), 32'd1);
    tick();
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    collect_wb("bm_clear");

    // READY entry squashed: writeback dropped in the resolve cycle
    drive_load(6'd31, 32'h404, LF_LB, 4'b0001, 4'b0100, 32'h0000007F, 4'b0001);
    check("sq_ready_before", 32'(lb_wb_valid), 32'd1);
    b_mm_resolve = 4'b0100;
    b_mm_mispred = 1'b1;
    #1;
    check("sq_ready_same_cycle", 32'(lb_wb_valid), 32'd0);
    tick();
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    check("sq_ready_after", 32'(lb_wb_valid), 32'd0);

    // Squashed input packet is not allocated
    b_mm_resolve = 4'b1000;
    b_mm_mispred = 1'b1;
    drive_load(6'd32, 32'h408, LF_LW, 4'hF, 4'b1000, '0, '0);
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    check("sq_input_no_req", 32'(dc_req_valid), 32'd0);

    // Reset with two loads in WAIT, then stale responses
    drive_load(6'd50, 32'h700, LF_LW, 4'hF, '0, '0, '0);
    drive_load(6'd51, 32'h704, LF_LW, 4'hF, '0, '0, '0);
    dc_req_accept = 1'b1;
    repeat (2) tick();
    dc_req_accept = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dc_resp_valid = 1'b1;
      dc_resp_tag = LB_IDX_W'(k);
      dc_resp_data = 32'h12345678;
      tick();
    end
    dc_resp_valid = 1'b0;
    tick();
    check("post_rst_wb", 32'(lb_wb_valid), 32'd0);
    check("post_rst_req", 32'(dc_req_valid), 32'd0);
    check("post_rst_free", 32'(load_buffer_free), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
